fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and ROM address width.
REQ-002 SHALL have parameter DATA_W, default 32, instruction width.
REQ-003 SHALL have parameter QDEPTH, default 4, instruction queue entries; power of two, >=2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port: clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port: jmp_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port: jmp_addr  input  ADDR_W  redirect target.
REQ-009 SHALL have port: excpt  input  1  exception/interrupt redirect request.
REQ-010 SHALL have port: excpt_pc  input  ADDR_W  exception handler target.
REQ-011 SHALL have port: rom_ce  output  1  ROM read enable.
REQ-012 SHALL have port: rom_addr  output  ADDR_W  ROM read address.
REQ-013 SHALL have port: rom_data  input  DATA_W  ROM read data, valid exactly one cycle after rom_ce.
REQ-014 SHALL have port: id_valid  output  1  queue head valid toward decode.
REQ-015 SHALL have port: id_ready  input  1  decode accepts head.
REQ-016 SHALL have ports: id_pc  output  ADDR_W and id_inst  output  DATA_W  head PC and instruction.
REQ-017 SHALL have port: misalign_err  output  1  one-cycle pulse on misaligned redirect (FETCH_MISALIGN_EN only; tied 0 otherwise).

Function
REQ-018 SHALL hold state machine states INIT, RUN, HALT; INIT lasts one cycle after rst deasserts, then RUN.
REQ-019 SHALL assert rom_ce in RUN only when (queue count + in-flight) < QDEPTH and no redirect is active this cycle.
REQ-020 SHALL drive rom_addr = fetch PC; fetch PC increments by DATA_W/8 on each cycle with rom_ce=1, wrapping modulo 2^ADDR_W.
REQ-021 SHALL push {fetch PC of request, rom_data} into the queue one cycle after each accepted request unless that request was squashed.
REQ-022 SHALL pop the head when id_valid && id_ready; simultaneous push and pop at full or empty SHALL keep count unchanged and data ordered.
REQ-023 SHALL give excpt priority over jmp_valid; a redirect loads fetch PC with the target, clears the queue, and squashes any in-flight response.
REQ-024 SHALL issue the first fetch at the redirect target on the cycle after the redirect; id_valid SHALL be 0 on that cycle.
REQ-025 SHALL ignore id_ready on a redirect cycle (head not consumed, id_valid forced 0).
REQ-026 SHALL never overflow: no push when full; proven by REQ-019 accounting.

Reset
REQ-027 SHALL on rst: fetch PC=RESET_PC, state=INIT, queue empty, in-flight cleared, rom_ce=0, id_valid=0, misalign_err=0.
REQ-028 SHALL let rst override any redirect or handshake in the same cycle; a response in flight at reset is discarded.

Configuration
REQ-029 SHALL with FETCH_MISALIGN_EN defined: redirect target with low log2(DATA_W/8) bits nonzero pulses misalign_err, flushes, enters HALT (rom_ce=0) until the next aligned redirect, which returns to RUN.
REQ-030 SHALL without FETCH_MISALIGN_EN: no HALT state, target used unchanged, misalign_err=0.

Structure
REQ-031 SHALL place state encoding (INIT/RUN/HALT) and the default ADDR_W/DATA_W/RESET_PC constants in shared package fetch_pkg.
REQ-032 SHALL implement the queue as sub-module fetch_fifo (parametrised width/depth, push/pop/flush, count output).

Verification
REQ-033 Reset release, id_ready=1, ROM returns addr as data -> rom_addr 0,4,8,...; id_pc/id_inst 0/0,4/4 from cycle 3 onward, one per cycle.
REQ-034 id_ready=0 for 10 cycles, QDEPTH=4 -> exactly 4 entries held, rom_ce=0 once full, no loss; release -> order 0,4,8,12.
REQ-035 jmp_valid with jmp_addr=0x100 while one fetch in flight -> in-flight dropped, next rom_addr=0x100, next id_pc=0x100.
REQ-036 excpt (excpt_pc=0x80) and jmp_valid (0x200) same cycle -> rom_addr=0x80 next cycle; 0x200 never fetched.
REQ-037 FETCH_MISALIGN_EN, jmp_addr=0x102 -> misalign_err one cycle, rom_ce stays 0; then jmp_addr=0x200 -> fetch resumes at 0x200.
REQ-038 rst asserted mid-stream with queue at 3 entries -> next cycle id_valid=0, rom_ce=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding and default geometry.
// The HALT state is only reachable when FETCH_MISALIGN_EN is defined.
package fetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = '0;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Bytes covered by one instruction word; the fetch PC advances by this much.
  function automatic int step_bytes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two circular buffer with push/pop/flush and an occupancy count.
// Flush (and reset) win over push and pop in the same cycle.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             clear;

  assign clear   = rst || flush;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop && !empty;
  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (do_push && !do_pop) begin
        count <= count + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential PC fetch from a 1-cycle-latency ROM into a decode queue,
// with jump/exception redirects. Define FETCH_MISALIGN_EN to halt on misaligned redirect targets.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                QDEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              excpt,
  input  logic [ADDR_W-1:0] excpt_pc,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] id_pc,
  output logic [DATA_W-1:0] id_inst,
  output logic              misalign_err,
  output fetch_state_e      fsm_state
);

  // Handshake: the head moves to decode on a cycle where id_valid && id_ready are both high
  // at the rising edge; id_valid never depends on id_ready, and is forced low on reset/redirect.

  localparam int CNT_W = $clog2(QDEPTH) + 1;
  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(step_bytes(DATA_W));
  localparam logic [CNT_W:0]    QDEPTH_L = (CNT_W+1)'(QDEPTH);

  fetch_state_e state;
  fetch_state_e state_next;

  logic [ADDR_W-1:0]        fetch_pc;
  logic [ADDR_W-1:0]        fetch_pc_next;
  logic [ADDR_W-1:0]        req_pc;
  logic [ADDR_W-1:0]        target;
  logic                     inflight;
  logic                     redirect;
  logic                     misaligned;
  logic                     fetch_en;
  logic                     push;
  logic                     pop;
  logic                     empty;
  logic [CNT_W-1:0]         count;
  logic [CNT_W:0]           occupancy;
  logic [ADDR_W+DATA_W-1:0] head;

  assign redirect = !rst && (excpt || jmp_valid);
  assign target   = excpt ? excpt_pc : jmp_addr;

`ifdef FETCH_MISALIGN_EN
  localparam logic [ADDR_W-1:0] ALIGN_MASK = PC_STEP - ADDR_W'(1);
  assign misaligned = |(target & ALIGN_MASK);
`else
  assign misaligned = 1'b0;
`endif

  // Outstanding ROM read counts against queue space so a response always has a slot.
  assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};

  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    fetch_en      = 1'b0;
    case (state)
      INIT:    state_next = RUN;
      RUN:     fetch_en   = !redirect && (occupancy < QDEPTH_L);
      HALT:    state_next = HALT;
      default: state_next = INIT;
    endcase
    if (rst) begin
      fetch_en = 1'b0;
    end
    if (redirect) begin
      fetch_pc_next = target;
      state_next    = misaligned ? HALT : RUN;
    end else if (fetch_en) begin
      fetch_pc_next = fetch_pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= INIT;
      fetch_pc     <= RESET_PC;
      req_pc       <= '0;
      inflight     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      fetch_pc     <= fetch_pc_next;
      inflight     <= fetch_en;
      misalign_err <= redirect && misaligned;
      if (fetch_en) begin
        req_pc <= fetch_pc;
      end
    end
  end

  // A response landing on a redirect cycle belongs to the abandoned stream.
  assign push = inflight && !redirect;
  assign pop  = id_valid && id_ready;

  fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (push),
    .push_data ({req_pc, rom_data}),
    .pop       (pop),
    .head      (head),
    .empty     (empty),
    .count     (count)
  );

  assign rom_ce    = fetch_en;
  assign rom_addr  = fetch_pc;
  assign id_valid  = !rst && !redirect && !empty;
  assign id_pc     = head[ADDR_W+DATA_W-1 -: ADDR_W];
  assign id_inst   = head[DATA_W-1:0];
  assign fsm_state = state;

endmodule
